// File: rtl/ysyx_22050550_ifu_fetch.sv
// ---------------------------------------------------------------------------
// ysyx_22050550_ifu_fetch
//
// Instruction fetch unit. It latches the next PC offered by the PC register,
// reads the aligned doubleword that holds it over an AR/R read channel, picks
// out the 32-bit instruction and presents {pc, inst, err} to the decode stage
// with a valid/ready handshake. Each instruction that decode takes produces a
// one-cycle advance pulse back to the PC register. A redirect from decode
// (flush_i) throws away whatever fetch is in flight.
//
// Ports
//   clock, reset      clock; synchronous active-high reset
//   pc_i              next PC from the PC register (the jump target during a flush)
//   pc_ready_o        one-cycle advance pulse to the PC register
//   flush_i           redirect taken in decode
//   mem_ar*           read address channel (valid/ready/addr)
//   mem_r*            read data channel (valid/ready/data/resp)
//   if_valid_o        instruction valid towards decode
//   if_ready_i        decode accepts the instruction
//   if_pc_o           PC of the presented instruction
//   if_inst_o         instruction word
//   if_err_o          fetch fault (bus error or misaligned PC)
// ---------------------------------------------------------------------------
module ysyx_22050550_ifu_fetch #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int INST_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_ready_o,
    input  logic              flush_i,
    output logic              mem_arvalid_o,
    input  logic              mem_arready_i,
    output logic [ADDR_W-1:0] mem_araddr_o,
    input  logic              mem_rvalid_i,
    output logic              mem_rready_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic [1:0]        mem_rresp_i,
    output logic              if_valid_o,
    input  logic              if_ready_i,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic              if_err_o
);

    // Instruction lanes inside one bus beat, and the number of byte-offset
    // bits that the bus address drops.
    localparam int LANES = DATA_W / INST_W;
    localparam int OFF_W = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic              drop_q, drop_d;     // the outstanding response belongs to a flushed fetch
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              err_q, err_d;

    // Split the beat into instruction-sized lanes; the PC bits just above the
    // instruction alignment choose which lane is the fetched instruction.
    logic [INST_W-1:0] lane_w [LANES];
    logic [INST_W-1:0] fetch_word;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_w[gi] = mem_rdata_i[gi*INST_W +: INST_W];
        end
    endgenerate

    assign fetch_word = lane_w[req_pc_q[OFF_W-1:2]];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            drop_q   <= 1'b0;
            req_pc_q <= '0;
            inst_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            drop_q   <= drop_d;
            req_pc_q <= req_pc_d;
            inst_q   <= inst_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        req_pc_d   = req_pc_q;
        inst_d     = inst_q;
        err_d      = err_q;
        pc_ready_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                // pc_i is already the redirect target if a flush is present,
                // so IDLE needs no flush handling of its own.
                req_pc_d = pc_i;
                if (pc_i[1:0] != 2'b00) begin
                    // Misaligned PC: report a fault without touching the bus.
                    inst_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                // The address must stay put until accepted, so a flush here
                // only marks the eventual response as stale.
                if (flush_i) begin
                    drop_d = 1'b1;
                end
                if (mem_arready_i) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (mem_rvalid_i) begin
                    if (drop_q || flush_i) begin
                        // Stale response: swallow it; nothing is outstanding afterwards.
                        drop_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        inst_d  = fetch_word;
                        err_d   = |mem_rresp_i;
                        state_d = S_HOLD;
                    end
                end else if (flush_i) begin
                    drop_d = 1'b1;
                end
            end

            S_HOLD: begin
                // A flush retracts the instruction; the PC register updates
                // itself on a flush, so no advance pulse is given then.
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (if_ready_i) begin
                    pc_ready_o = 1'b1;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_arvalid_o = (state_q == S_REQ);
    assign mem_araddr_o  = {req_pc_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_rready_o  = (state_q == S_WAIT);

    assign if_valid_o = (state_q == S_HOLD);
    assign if_pc_o    = req_pc_q;
    assign if_inst_o  = inst_q;
    assign if_err_o   = err_q;

endmodule

// File: tb/tb_ysyx_22050550_ifu_fetch.sv
module tb_ysyx_22050550_ifu_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] pc_i = '0;
    logic        flush_i = 1'b0;
    logic        mem_arready_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;
    logic [1:0]  mem_rresp_i = '0;
    logic        if_ready_i = 1'b0;

    logic        pc_ready_o;
    logic        mem_arvalid_o;
    logic [63:0] mem_araddr_o;
    logic        mem_rready_o;
    logic        if_valid_o;
    logic [63:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_err_o;

    ysyx_22050550_ifu_fetch #(
        .ADDR_W(64),
        .DATA_W(64),
        .INST_W(32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pc_i         (pc_i),
        .pc_ready_o   (pc_ready_o),
        .flush_i      (flush_i),
        .mem_arvalid_o(mem_arvalid_o),
        .mem_arready_i(mem_arready_i),
        .mem_araddr_o (mem_araddr_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rready_o (mem_rready_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_rresp_i  (mem_rresp_i),
        .if_valid_o   (if_valid_o),
        .if_ready_i   (if_ready_i),
        .if_pc_o      (if_pc_o),
        .if_inst_o    (if_inst_o),
        .if_err_o     (if_err_o)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One record per clock cycle: inputs driven in that cycle and the outputs
    // expected while they are applied. Payload fields are compared only when
    // an instruction is presented (or on "full" rows, where everything is 0).
    typedef struct {
        logic        rst;
        logic [63:0] pc;
        logic        fl;
        logic        ar;
        logic        rv;
        logic [63:0] rd;
        logic [1:0]  rr;
        logic        ir;
        logic        e_arv;
        logic [63:0] e_ara;
        logic        e_rrdy;
        logic        e_v;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
        logic        e_err;
        logic        e_pcr;
        logic        full;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [63:0] pc, input logic fl, input logic ar,
                       input logic rv, input logic [63:0] rd, input logic [1:0] rr, input logic ir,
                       input logic e_arv, input logic [63:0] e_ara, input logic e_rrdy,
                       input logic e_v, input logic [63:0] e_pc, input logic [31:0] e_inst,
                       input logic e_err, input logic e_pcr, input logic full);
        vec_t v;
        v.rst = rst; v.pc = pc; v.fl = fl; v.ar = ar; v.rv = rv; v.rd = rd; v.rr = rr; v.ir = ir;
        v.e_arv = e_arv; v.e_ara = e_ara; v.e_rrdy = e_rrdy; v.e_v = e_v; v.e_pc = e_pc;
        v.e_inst = e_inst; v.e_err = e_err; v.e_pcr = e_pcr; v.full = full;
        vecs.push_back(v);
    endtask

    // Behavioural memory used by the random phase: contents and error
    // responses are pure functions of the doubleword address.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0] + 32'h0123_4567};
    endfunction

    function automatic logic [1:0] mem_resp(input logic [63:0] a);
        return (a[5:3] == 3'b101) ? 2'b10 : 2'b00;
    endfunction

    localparam logic [63:0] D1 = 64'h00100073_00000413;
    localparam logic [63:0] D2 = 64'h11111111_22222222;
    localparam logic [63:0] D3 = 64'hAAAAAAAA_BBBBBBBB;
    localparam logic [63:0] D4 = 64'h12345678_9ABCDEF0;

    initial begin
        vec_t        v;
        logic [63:0] pc_cur;
        logic [63:0] tgt;
        logic [63:0] ar_q[$];
        logic [63:0] w;
        logic [63:0] prev_araddr;
        logic [63:0] prev_pc;
        logic [31:0] prev_inst;
        logic        prev_err;
        logic        prev_ar_stall;
        logic        prev_hold;
        logic        do_rst;
        logic [31:0] exp_inst;
        logic        exp_err;
        int          since_accept;
        int          accepts;

        //    rst pc            fl ar rv rdata rr ir   arv araddr        rr v  pc            inst          er pr full
        add(1, 64'h80000000, 0, 0, 0, 0,  0, 0,  0, 0,            0, 0, 0,            0,            0, 0, 1);
        // fetch at 0x80000000, zero-wait memory
        add(0, 64'h80000000, 0, 1, 0, 0,  0, 0,  0, 0,            0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000000, 0, 1, 0, 0,  0, 0,  1, 64'h80000000, 0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000000, 0, 1, 1, D1, 0, 0,  0, 0,            1, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000000, 0, 1, 0, 0,  0, 1,  0, 0,            0, 1, 64'h80000000, 32'h00000413, 0, 1, 0);
        // upper word at 0x80000004, then hold with ID stalled for 5 cycles
        add(0, 64'h80000004, 0, 1, 0, 0,  0, 0,  0, 0,            0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000004, 0, 1, 0, 0,  0, 0,  1, 64'h80000000, 0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000004, 0, 1, 1, D1, 0, 0,  0, 0,            1, 0, 0,            0,            0, 0, 0);
        for (int k = 0; k < 5; k++)
            add(0, 64'h80000004, 0, 1, 0, 0, 0, 0, 0, 0,          0, 1, 64'h80000004, 32'h00100073, 0, 0, 0);
        add(0, 64'h80000004, 0, 1, 0, 0,  0, 1,  0, 0,            0, 1, 64'h80000004, 32'h00100073, 0, 1, 0);
        // next fetch follows the advanced PC
        add(0, 64'h80000008, 0, 1, 0, 0,  0, 0,  0, 0,            0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000008, 0, 1, 0, 0,  0, 0,  1, 64'h80000008, 0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000008, 0, 1, 1, D2, 0, 0,  0, 0,            1, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000008, 0, 1, 0, 0,  0, 1,  0, 0,            0, 1, 64'h80000008, 32'h22222222, 0, 1, 0);
        // flush while waiting for data, stale response later
        add(0, 64'h8000000C, 0, 1, 0, 0,  0, 0,  0, 0,            0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h8000000C, 0, 1, 0, 0,  0, 0,  1, 64'h80000008, 0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000100, 1, 1, 0, 0,  0, 1,  0, 0,            1, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000100, 0, 1, 1, D1, 0, 1,  0, 0,            1, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000100, 0, 1, 0, 0,  0, 1,  0, 0,            0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000100, 0, 1, 0, 0,  0, 1,  1, 64'h80000100, 0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000100, 0, 1, 1, D3, 0, 1,  0, 0,            1, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000100, 0, 1, 0, 0,  0, 1,  0, 0,            0, 1, 64'h80000100, 32'hBBBBBBBB, 0, 1, 0);
        // flush during a stalled address phase
        add(0, 64'h80000104, 0, 0, 0, 0,  0, 0,  0, 0,            0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000200, 1, 0, 0, 0,  0, 1,  1, 64'h80000100, 0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000200, 0, 0, 0, 0,  0, 1,  1, 64'h80000100, 0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000200, 0, 0, 0, 0,  0, 1,  1, 64'h80000100, 0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000200, 0, 1, 0, 0,  0, 1,  1, 64'h80000100, 0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000200, 0, 1, 1, D1, 0, 1,  0, 0,            1, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000200, 0, 1, 0, 0,  0, 1,  0, 0,            0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000200, 0, 1, 0, 0,  0, 1,  1, 64'h80000200, 0, 0, 0,            0,            0, 0, 0);
        // bus error response
        add(0, 64'h80000200, 0, 1, 1, D4, 2, 1,  0, 0,            1, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000200, 0, 1, 0, 0,  0, 1,  0, 0,            0, 1, 64'h80000200, 32'h9ABCDEF0, 1, 1, 0);
        // misaligned PC: no bus traffic, fault presented directly
        add(0, 64'h80000002, 0, 1, 0, 0,  0, 1,  0, 0,            0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000002, 0, 1, 0, 0,  0, 1,  0, 0,            0, 1, 64'h80000002, 32'h00000000, 1, 1, 0);
        // reset while waiting for data, then restart
        add(0, 64'h80000008, 0, 1, 0, 0,  0, 0,  0, 0,            0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000008, 0, 1, 0, 0,  0, 0,  1, 64'h80000008, 0, 0, 0,            0,            0, 0, 0);
        add(1, 64'h80000008, 0, 0, 0, 0,  0, 0,  0, 0,            1, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000010, 0, 1, 0, 0,  0, 0,  0, 0,            0, 0, 0,            0,            0, 0, 1);
        add(0, 64'h80000010, 0, 1, 0, 0,  0, 0,  1, 64'h80000010, 0, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000010, 0, 1, 1, D2, 0, 0,  0, 0,            1, 0, 0,            0,            0, 0, 0);
        add(0, 64'h80000010, 0, 1, 0, 0,  0, 1,  0, 0,            0, 1, 64'h80000010, 32'h22222222, 0, 1, 0);

        repeat (2) @(posedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(posedge clock);
            #1;
            reset = v.rst; pc_i = v.pc; flush_i = v.fl; mem_arready_i = v.ar;
            mem_rvalid_i = v.rv; mem_rdata_i = v.rd; mem_rresp_i = v.rr; if_ready_i = v.ir;
            @(negedge clock);
            chk($sformatf("v%0d_arvalid", i), 64'(mem_arvalid_o), 64'(v.e_arv));
            chk($sformatf("v%0d_rready", i), 64'(mem_rready_o), 64'(v.e_rrdy));
            chk($sformatf("v%0d_if_valid", i), 64'(if_valid_o), 64'(v.e_v));
            chk($sformatf("v%0d_pc_ready", i), 64'(pc_ready_o), 64'(v.e_pcr));
            if (v.e_arv || v.full)
                chk($sformatf("v%0d_araddr", i), mem_araddr_o, v.e_ara);
            if (v.e_v || v.full) begin
                chk($sformatf("v%0d_if_pc", i), if_pc_o, v.e_pc);
                chk($sformatf("v%0d_if_inst", i), 64'(if_inst_o), 64'(v.e_inst));
                chk($sformatf("v%0d_if_err", i), 64'(if_err_o), 64'(v.e_err));
            end
        end

        // Random phase: the bench plays PC register, memory and decode stage.
        // Whatever decode accepts must be the instruction at the bench's own PC.
        @(posedge clock);
        #1;
        reset = 1'b1; flush_i = 1'b0; mem_arready_i = 1'b0; mem_rvalid_i = 1'b0; if_ready_i = 1'b0;
        pc_cur = 64'h80000000;
        pc_i = pc_cur;
        repeat (2) @(posedge clock);
        ar_q.delete();
        prev_ar_stall = 1'b0;
        prev_hold = 1'b0;
        prev_araddr = '0; prev_pc = '0; prev_inst = '0; prev_err = 1'b0;
        since_accept = 0;
        accepts = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clock);
            #1;
            do_rst = ($urandom_range(0, 299) == 0);
            reset = do_rst;
            flush_i = !do_rst && ($urandom_range(0, 15) == 0);
            if (flush_i) begin
                tgt = 64'h80000000 + 64'($urandom_range(0, 4095)) * 4;
                if ($urandom_range(0, 9) == 0) tgt[1] = 1'b1;
                pc_cur = tgt;
            end
            pc_i = pc_cur;
            mem_arready_i = !do_rst && ($urandom_range(0, 1) == 1);
            if (!do_rst && ar_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i = mem_word(ar_q[0]);
                mem_rresp_i = mem_resp(ar_q[0]);
            end else if (!do_rst && ar_q.size() == 0 && $urandom_range(0, 3) == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i = {$urandom, $urandom};
                mem_rresp_i = 2'($urandom_range(0, 3));
            end else begin
                mem_rvalid_i = 1'b0;
            end
            if_ready_i = !do_rst && ($urandom_range(0, 2) != 0);

            @(negedge clock);
            chk("rnd_pc_ready", 64'(pc_ready_o), 64'(if_valid_o && if_ready_i && !flush_i));
            if (mem_rready_o)
                chk("rnd_rready_outstanding", 64'(ar_q.size()), 64'd1);
            if (mem_arvalid_o) begin
                chk("rnd_arvalid_outstanding", 64'(ar_q.size()), 64'd0);
                chk("rnd_araddr_align", 64'(mem_araddr_o[2:0]), 64'd0);
            end
            if (prev_ar_stall) begin
                chk("rnd_arvalid_held", 64'(mem_arvalid_o), 64'd1);
                chk("rnd_araddr_held", mem_araddr_o, prev_araddr);
            end
            if (prev_hold) begin
                chk("rnd_valid_held", 64'(if_valid_o), 64'd1);
                chk("rnd_pc_held", if_pc_o, prev_pc);
                chk("rnd_inst_held", 64'(if_inst_o), 64'(prev_inst));
                chk("rnd_err_held", 64'(if_err_o), 64'(prev_err));
            end
            if (if_valid_o && if_ready_i && !flush_i) begin
                if (pc_cur[1:0] != 2'b00) begin
                    exp_inst = '0;
                    exp_err = 1'b1;
                end else begin
                    w = mem_word({pc_cur[63:3], 3'b000});
                    exp_inst = pc_cur[2] ? w[63:32] : w[31:0];
                    exp_err = (mem_resp({pc_cur[63:3], 3'b000}) != 2'b00);
                end
                chk("rnd_if_pc", if_pc_o, pc_cur);
                chk("rnd_if_inst", 64'(if_inst_o), 64'(exp_inst));
                chk("rnd_if_err", 64'(if_err_o), 64'(exp_err));
                pc_cur = pc_cur + 64'd4;
                since_accept = 0;
                accepts++;
            end else begin
                since_accept++;
            end

            if (mem_arvalid_o && mem_arready_i) ar_q.push_back(mem_araddr_o);
            if (mem_rvalid_i && mem_rready_o && ar_q.size() > 0) void'(ar_q.pop_front());

            prev_ar_stall = !do_rst && mem_arvalid_o && !mem_arready_i;
            prev_araddr = mem_araddr_o;
            prev_hold = !do_rst && if_valid_o && !if_ready_i && !flush_i;
            prev_pc = if_pc_o;
            prev_inst = if_inst_o;
            prev_err = if_err_o;
            if (do_rst) ar_q.delete();

            if (since_accept > 300) begin
                chk("rnd_progress_timeout", 64'(since_accept), 64'd300);
                break;
            end
        end
        chk("rnd_some_accepts", 64'(accepts > 100), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
